tmds_encoder: RTL and testbench
===============================

TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001: INVERT_OUT, default 0; when 1, Encoded is the bitwise complement of the TMDS symbol, for boards with swapped P/N pairs.
REQ-002: Clk  input  1  pixel clock; all state updates on rising edge.
REQ-003: Reset_n  input  1  reset; asynchronous assert, active-low.
REQ-004: VideoData  input  8  pixel component byte; sampled when DataEnable=1.
REQ-005: Ctrl  input  2  control bits {C1,C0}; sampled when DataEnable=0.
REQ-006: DataEnable  input  1  1 = video period, 0 = control/blanking period.
REQ-007: Encoded  output  10  TMDS symbol; bit 0 is transmitted first; drives the 10:1 serialiser Data input directly.
REQ-008: DataEnableOut  output  1  DataEnable delayed to align with Encoded.

Function
REQ-009: The block is a 2-stage pipeline: inputs are registered in stage 1 and Encoded/DataEnableOut are registered in stage 2, so latency is exactly 2 Clk cycles, with one symbol per cycle and no stalls.
REQ-010: Stage 1 computes the 9-bit transition-minimised word q_m.
  - Let N1 = ones count of VideoData.
  - Use XNOR chaining (q_m[8]=0) when N1>4, or N1==4 with VideoData[0]==0.
  - Otherwise use XOR chaining (q_m[8]=1).
  - q_m[0] = VideoData[0].
REQ-011: Stage 2 keeps a signed 5-bit running disparity cnt, with range -16..+15 and no wrap in legal operation.
  - Let n1/n0 = ones/zeros count of q_m[7:0].
REQ-012: Case cnt==0 or n1==n0:
  - Out[9] = ~q_m[8]; Out[8] = q_m[8].
  - Out[7:0] = q_m[8] ? q_m[7:0] : ~q_m[7:0].
  - cnt += q_m[8] ? (n1-n0) : (n0-n1).
REQ-013: Case (cnt>0 and n1>n0) or (cnt<0 and n0>n1):
  - Out[9] = 1; Out[8] = q_m[8]; Out[7:0] = ~q_m[7:0].
  - cnt += 2*q_m[8] + (n0-n1).
REQ-014: Otherwise:
  - Out[9] = 0; Out[8] = q_m[8]; Out[7:0] = q_m[7:0].
  - cnt += (n1-n0) - 2*(~q_m[8]).
REQ-015: When the stage-2 DataEnable is 0, Out is the control token for Ctrl and cnt is forced to 0:
  - 00 -> 10'b1101010100
  - 01 -> 10'b0010101011
  - 10 -> 10'b0101010100
  - 11 -> 10'b1010101011
REQ-016: On a DataEnable 0->1 transition, the first video symbol is encoded from cnt=0; on a 1->0 transition, the token is emitted in the same cycle that cnt clears.
REQ-017: Encoded = Out ^ {10{INVERT_OUT}}.

Reset
REQ-018: While Reset_n=0:
  - all pipeline registers clear;
  - cnt = 0;
  - DataEnableOut = 0;
  - Encoded = control token 00 (10'b1101010100), XOR INVERT_OUT.
REQ-019: Reset asserted mid-stream discards in-flight symbols; after release, the first two cycles output the reset token, then encoded inputs follow with 2-cycle latency.

Structure
REQ-020: A shared package holds the four control-token constants and a ones-count function.
REQ-021: Stage 1 is a sub-module tmds_qm_stage (registered VideoData -> q_m, plus pipelined DataEnable and Ctrl).

Verification
REQ-022: Reset_n=0, then release with DataEnable=0 and Ctrl=00 -> Encoded=10'b1101010100 and DataEnableOut=0 throughout.
REQ-023: From cnt=0, DataEnable=1 with VideoData=0x00 for two cycles -> Encoded=10'b0100000000 (cnt becomes -8), then 10'b1111111111 (cnt becomes +2), each 2 cycles after its input.
REQ-024: From cnt=0, VideoData=0xFF -> Encoded=10'b1000000000 and cnt=-8.
REQ-025: DataEnable=0 while stepping Ctrl through 00, 01, 10, 11 -> the four tokens of REQ-015, in order, at 2-cycle latency; cnt reads 0.
REQ-026: 10,000 random bytes with DataEnable=1 -> a reference-model decode matches every input byte, and cumulative disparity stays within ±16.
REQ-027: INVERT_OUT=1, repeat REQ-022 -> Encoded=10'b0010101011.

Source files
------------

// File: rtl/tmds_encoder_pkg.sv
// TMDS encoder shared definitions.
//   - The four control-period tokens, indexed by {C1,C0}.
//   - ones8(): population count of a byte, used by both pipeline stages.
//   - qm_word_t: the stage-1 pipeline register contents.
package tmds_encoder_pkg;

  localparam logic [9:0] TOK_00 = 10'b1101010100;
  localparam logic [9:0] TOK_01 = 10'b0010101011;
  localparam logic [9:0] TOK_10 = 10'b0101010100;
  localparam logic [9:0] TOK_11 = 10'b1010101011;

  typedef struct packed {
    logic [8:0] q_m;   // transition-minimised word, q_m[8]=1 means XOR chaining
    logic       de;    // DataEnable delayed by one cycle
    logic [1:0] ctrl;  // Ctrl delayed by one cycle
  } qm_word_t;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = TOK_00;
      2'b01:   t = TOK_01;
      2'b10:   t = TOK_10;
      default: t = TOK_11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_encoder_if.sv
// Pixel-side bus of the TMDS encoder.
//   VideoData[7:0]  pixel component byte (used while DataEnable=1)
//   Ctrl[1:0]       {C1,C0} control bits (used while DataEnable=0)
//   DataEnable      1 = video period, 0 = control/blanking period
//   Encoded[9:0]    TMDS symbol, bit 0 transmitted first
//   DataEnableOut   DataEnable aligned with Encoded
// master = pixel source, slave = encoder.
interface tmds_encoder_if;
  logic [7:0] VideoData;
  logic [1:0] Ctrl;
  logic       DataEnable;
  logic [9:0] Encoded;
  logic       DataEnableOut;

  modport master (output VideoData, Ctrl, DataEnable, input  Encoded, DataEnableOut);
  modport slave  (input  VideoData, Ctrl, DataEnable, output Encoded, DataEnableOut);
endinterface

// File: rtl/tmds_qm_stage.sv
// TMDS stage 1: transition minimisation.
// Builds the 9-bit q_m word from VideoData and registers it together with
// DataEnable and Ctrl so stage 2 sees all three aligned.
//   Clk, Reset_n   pixel clock, async active-low reset (clears to control 00)
//   VideoData      input byte
//   Ctrl           control bits
//   DataEnable     video/control select
//   stage1         registered {q_m, de, ctrl}
module tmds_qm_stage
  import tmds_encoder_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] VideoData,
  input  logic [1:0] Ctrl,
  input  logic       DataEnable,
  output qm_word_t   stage1
);

  logic [3:0] n1;
  logic       use_xnor;
  logic [8:0] qm;

  // XNOR chaining is chosen for ones-heavy bytes (ties broken by bit 0) so
  // the chained word ends up with fewer transitions.
  always_comb begin
    n1       = ones8(VideoData);
    use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !VideoData[0]);
    qm       = '0;
    qm[0]    = VideoData[0];
    for (int i = 1; i < 8; i++)
      qm[i] = qm[i-1] ^ VideoData[i] ^ use_xnor;
    qm[8]    = ~use_xnor;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) stage1 <= '0;
    else          stage1 <= '{q_m: qm, de: DataEnable, ctrl: Ctrl};
  end

endmodule

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b encoder, 2-cycle latency, one symbol per clock, no stalls.
// Stage 1 (tmds_qm_stage) produces q_m; stage 2 balances DC using a signed
// running disparity cnt and emits control tokens during blanking.
//   INVERT_OUT   1 = complement Encoded (swapped P/N board routing)
//   Clk          pixel clock
//   Reset_n      async active-low reset; output parks on control token 00
//   bus          tmds_encoder_if.slave (VideoData/Ctrl/DataEnable in,
//                Encoded/DataEnableOut out)
module tmds_encoder
  import tmds_encoder_pkg::*;
#(
  parameter bit INVERT_OUT = 1'b0
)(
  input  logic           Clk,
  input  logic           Reset_n,
  tmds_encoder_if.slave  bus
);

  qm_word_t          s1;
  logic signed [4:0] cnt, cnt_nxt;   // running disparity of emitted symbols
  logic signed [4:0] diff;           // n1 - n0 of q_m[7:0]
  logic        [3:0] n1;
  logic        [9:0] sym, sym_nxt;
  logic              deo;
  logic              q8;

  tmds_qm_stage u_qm (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .VideoData  (bus.VideoData),
    .Ctrl       (bus.Ctrl),
    .DataEnable (bus.DataEnable),
    .stage1     (s1)
  );

  // n1 - n0 = 2*n1 - 8. The 5-bit intermediate wraps for n1=8 but the
  // modular result (+8) is exact, and every sum below stays in -16..+15.
  always_comb begin
    n1      = ones8(s1.q_m[7:0]);
    diff    = $signed({n1, 1'b0}) - 5'sd8;
    q8      = s1.q_m[8];
    sym_nxt = ctrl_token(s1.ctrl);
    cnt_nxt = '0;
    if (s1.de) begin
      if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
        sym_nxt = {~q8, q8, q8 ? s1.q_m[7:0] : ~s1.q_m[7:0]};
        cnt_nxt = cnt + (q8 ? diff : -diff);
      end else if (((cnt > 5'sd0) && (diff > 5'sd0)) ||
                   ((cnt < 5'sd0) && (diff < 5'sd0))) begin
        // Current symbol would worsen the imbalance: send it inverted.
        sym_nxt = {1'b1, q8, ~s1.q_m[7:0]};
        cnt_nxt = cnt + (q8 ? 5'sd2 : 5'sd0) - diff;
      end else begin
        sym_nxt = {1'b0, q8, s1.q_m[7:0]};
        cnt_nxt = cnt + diff - (q8 ? 5'sd0 : 5'sd2);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sym <= TOK_00;
      cnt <= '0;
      deo <= 1'b0;
    end else begin
      sym <= sym_nxt;
      cnt <= cnt_nxt;
      deo <= s1.de;
    end
  end

  assign bus.Encoded       = sym ^ {10{INVERT_OUT}};
  assign bus.DataEnableOut = deo;

endmodule

// File: tb/tb_tmds_encoder.sv
module tb_tmds_encoder;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] tb_vd = '0;
  logic [1:0] tb_ctrl = '0;
  logic       tb_de = 1'b0;

  always #5 Clk = ~Clk;

  tmds_encoder_if bus0 ();
  tmds_encoder_if bus1 ();

  assign bus0.VideoData = tb_vd;   assign bus1.VideoData = tb_vd;
  assign bus0.Ctrl = tb_ctrl;      assign bus1.Ctrl = tb_ctrl;
  assign bus0.DataEnable = tb_de;  assign bus1.DataEnable = tb_de;

  tmds_encoder #(.INVERT_OUT(1'b0)) dut0 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus0.slave));
  tmds_encoder #(.INVERT_OUT(1'b1)) dut1 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus1.slave));

  localparam logic [9:0] T00 = 10'b1101010100;
  logic [9:0] tok [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};

  typedef struct {
    logic       de;
    logic [7:0] d;
    logic [1:0] c;
    logic [9:0] enc;
  } vec_t;

  typedef struct {
    logic [9:0] enc;
    logic       de;
    logic [7:0] d;
    bit         chk_dec;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt = 0;   // reference running disparity
  int   disp  = 0;   // disparity measured on the DUT output stream

  task automatic chk(input string name, input logic [9:0] got, input logic [9:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference encoder: chooses the chaining from the byte's ones count,
  // then picks plain/inverted form to steer the running disparity toward 0.
  function automatic logic [9:0] model(input logic de_i, input logic [7:0] d, input logic [1:0] c);
    int n1, bal;
    logic xn;
    logic [8:0] qm;
    logic [9:0] o;
    if (!de_i) begin
      m_cnt = 0;
      return tok[c];
    end
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && !d[0]);
    qm = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i] ^ xn;
    qm[8] = ~xn;
    bal = 2 * $countones(qm[7:0]) - 8;
    if (m_cnt == 0 || bal == 0) begin
      o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      m_cnt += qm[8] ? bal : -bal;
    end else if ((m_cnt > 0 && bal > 0) || (m_cnt < 0 && bal < 0)) begin
      o = {1'b1, qm[8], ~qm[7:0]};
      m_cnt += (qm[8] ? 2 : 0) - bal;
    end else begin
      o = {1'b0, qm[8], qm[7:0]};
      m_cnt += bal - (qm[8] ? 0 : 2);
    end
    return o;
  endfunction

  // Receiver-side decode of a data symbol back to the byte.
  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] w, d;
    w = s[9] ? ~s[7:0] : s[7:0];
    d[0] = w[0];
    for (int i = 1; i < 8; i++) d[i] = w[i] ^ w[i-1] ^ ~s[8];
    return d;
  endfunction

  // Apply one input, advance a clock, check the output for the input
  // applied one cycle earlier (two register stages -> 2-cycle latency).
  task automatic cyc(input logic de_i, input logic [7:0] d_i, input logic [1:0] c_i,
                     input logic [9:0] want, input bit chk_d);
    exp_t e;
    tb_de = de_i; tb_vd = d_i; tb_ctrl = c_i;
    q.push_back('{enc: want, de: de_i, d: d_i, chk_dec: chk_d});
    @(posedge Clk); #1;
    e = q.pop_front();
    chk("encoded", bus0.Encoded, e.enc);
    chk("encoded_inv", bus1.Encoded, ~e.enc);
    chk("de_out", {9'b0, bus0.DataEnableOut}, {9'b0, e.de});
    if (bus0.DataEnableOut) disp += 2 * $countones(bus0.Encoded) - 10;
    else disp = 0;
    if (e.chk_dec) begin
      chk("decode", {2'b0, decode(bus0.Encoded)}, {2'b0, e.d});
      chk("disparity_bound", {9'b0, (disp >= -16 && disp <= 16)}, 10'd1);
    end
  endtask

  task automatic do_reset();
    Reset_n = 1'b0; tb_de = 1'b0; tb_ctrl = 2'b00; tb_vd = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_encoded", bus0.Encoded, T00);
    chk("rst_encoded_inv", bus1.Encoded, ~T00);
    chk("rst_de_out", {9'b0, bus0.DataEnableOut}, 10'd0);
    Reset_n = 1'b1;
    q.delete();
    q.push_back('{enc: T00, de: 1'b0, d: 8'h00, chk_dec: 1'b0});
    m_cnt = 0;
    disp  = 0;
  endtask

  vec_t tbl [16];
  logic [7:0] rb;
  logic [1:0] rc;
  logic       rd;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 8'h00, 2'b00, 10'b1101010100};
    tbl[1]  = '{1'b0, 8'h00, 2'b01, 10'b0010101011};
    tbl[2]  = '{1'b0, 8'h00, 2'b10, 10'b0101010100};
    tbl[3]  = '{1'b0, 8'h00, 2'b11, 10'b1010101011};
    tbl[4]  = '{1'b1, 8'h00, 2'b00, 10'b0100000000};  // cnt 0 -> -8
    tbl[5]  = '{1'b1, 8'h00, 2'b00, 10'b1111111111};  // cnt -8 -> +2
    tbl[6]  = '{1'b0, 8'h00, 2'b00, 10'b1101010100};  // cnt cleared
    tbl[7]  = '{1'b1, 8'hFF, 2'b00, 10'b1000000000};  // cnt 0 -> -8
    tbl[8]  = '{1'b0, 8'h00, 2'b01, 10'b0010101011};
    tbl[9]  = '{1'b1, 8'h00, 2'b00, 10'b0100000000};  // cnt 0 -> -8
    tbl[10] = '{1'b1, 8'hFF, 2'b00, 10'b0011111111};  // cnt -8 -> -2
    tbl[11] = '{1'b1, 8'h00, 2'b00, 10'b1111111111};  // cnt -2 -> +8
    tbl[12] = '{1'b1, 8'h10, 2'b00, 10'b0111110000};  // balanced, cnt stays +8
    tbl[13] = '{1'b1, 8'h0F, 2'b00, 10'b0100000101};  // cnt +8 -> +4
    tbl[14] = '{1'b1, 8'h1E, 2'b00, 10'b0010100000};  // XNOR tie, cnt +4 -> -2
    tbl[15] = '{1'b0, 8'h00, 2'b11, 10'b1010101011};

    // Reset and idle control 00
    do_reset();
    repeat (4) cyc(1'b0, 8'h00, 2'b00, T00, 1'b0);

    // Directed vectors
    foreach (tbl[i]) cyc(tbl[i].de, tbl[i].d, tbl[i].c, tbl[i].enc, 1'b0);
    cyc(1'b0, 8'h00, 2'b00, T00, 1'b0);

    // Mid-stream asynchronous reset discards in-flight symbols
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      cyc(1'b1, rb, 2'b00, model(1'b1, rb, 2'b00), 1'b1);
    end
    tb_de = 1'b1; tb_vd = 8'h5A;
    #3 Reset_n = 1'b0;
    #1;
    chk("async_rst_encoded", bus0.Encoded, T00);
    chk("async_rst_de_out", {9'b0, bus0.DataEnableOut}, 10'd0);
    do_reset();
    cyc(1'b0, 8'h00, 2'b00, T00, 1'b0);
    cyc(1'b1, 8'h00, 2'b00, 10'b0100000000, 1'b0);   // encoded from cnt=0
    cyc(1'b0, 8'h00, 2'b00, T00, 1'b0);

    // Random video bytes against the reference model
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      rb = 8'($urandom);
      cyc(1'b1, rb, 2'b00, model(1'b1, rb, 2'b00), 1'b1);
    end

    // Random interleaving of video and blanking
    for (int i = 0; i < 400; i++) begin
      rb = 8'($urandom);
      rc = 2'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      cyc(rd, rb, rc, model(rd, rb, rc), rd);
    end
    cyc(1'b0, 8'h00, 2'b00, model(1'b0, 8'h00, 2'b00), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
